// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the lab CPU and its instruction
//               sequencer: instruction width, opcode encodings, the
//               sequencer state encoding and an opcode extraction helper.
//               Optional macro SEQ_BREAK_EN adds the PAUSE state.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W = 16;

    // Opcode lives in the top three bits of every instruction word
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_HALT      = 3'd5
`ifdef SEQ_BREAK_EN
        ,
        S_PAUSE     = 3'd6
`endif
    } seq_state_t;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Bundle between the instruction sequencer and its environment:
//               program-load port, run/status, and the CPU load/start
//               handshake. master = sequencer view, slave = environment view.
//               Signals:
//                 prog_we/prog_addr/prog_data : program write port
//                 run                         : start pulse
//                 cpu_waiting                 : CPU idle/ready status
//                 cpu_load/cpu_start          : CPU strobes
//                 cpu_instr                   : word presented to the CPU
//                 pc, busy, done              : sequencer status
//               Optional macro SEQ_BREAK_EN adds bp_en, bp_addr, bp_hit.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int AW = 4
);
    import cpu_pkg::*;

    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               run;
    logic               cpu_waiting;
    logic               cpu_load;
    logic               cpu_start;
    logic [INSTR_W-1:0] cpu_instr;
    logic [AW-1:0]      pc;
    logic               busy;
    logic               done;
`ifdef SEQ_BREAK_EN
    logic               bp_en;
    logic [AW-1:0]      bp_addr;
    logic               bp_hit;
`endif

    modport master (
        input  prog_we, prog_addr, prog_data, run, cpu_waiting,
`ifdef SEQ_BREAK_EN
        input  bp_en, bp_addr,
        output bp_hit,
`endif
        output cpu_load, cpu_start, cpu_instr, pc, busy, done
    );

    modport slave (
        output prog_we, prog_addr, prog_data, run, cpu_waiting,
`ifdef SEQ_BREAK_EN
        output bp_en, bp_addr,
        input  bp_hit,
`endif
        input  cpu_load, cpu_start, cpu_instr, pc, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/instr_rom_ram.sv
`default_nettype none
// ============================================================================
// Module      : instr_rom_ram
// Description : DEPTH x W program store. Synchronous write, combinational
//               read. Contents are not reset.
//               Ports: clk, we, waddr, wdata (write side); raddr, rdata (read)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_rom_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 16
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [W-1:0]  wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [W-1:0]  rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Feeds a stored program into the lab CPU. On a run pulse it
//               issues each word with a load/start handshake, waits for the
//               CPU to leave and re-enter its wait state, then advances the
//               PC. Stops on a HALT opcode or after the last memory word.
//               Ports: clk, rst_n (async, active low),
//                      bus (instr_sequencer_if.master).
//               Optional macro SEQ_BREAK_EN adds a PC breakpoint that parks
//               the sequencer in PAUSE until the next run pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int         DEPTH   = 16,
    parameter logic [2:0] HALT_OP = cpu_pkg::OP_HALT
) (
    input wire logic          clk,
    input wire logic          rst_n,
    instr_sequencer_if.master bus
);
    import cpu_pkg::*;

    localparam int            AW          = $clog2(DEPTH);
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_rd_data;
    logic               r_busy;
    logic               r_done;
    logic               w_run_accept;
    logic               w_last_word;
    logic               w_mem_we;
`ifdef SEQ_BREAK_EN
    logic               r_bp_hit;
`endif

    // A write that collides with an accepted run is dropped so the program
    // cannot change underneath the first fetch.
    assign w_mem_we = bus.prog_we && !r_busy && !w_run_accept;

    // Read port follows the next PC so the word is registered into
    // cpu_instr on the edge that enters LOAD, valid while cpu_load is high.
    instr_rom_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (INSTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (w_pc_nxt),
        .rdata (w_rd_data)
    );

    assign w_last_word = (opcode_of(r_instr) == HALT_OP) || (r_pc == C_LAST_ADDR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-PC logic
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_run_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.run && bus.cpu_waiting) begin
                    w_state_nxt  = S_LOAD;
                    w_pc_nxt     = '0;
                    w_run_accept = 1'b1;
                end
            end
            S_LOAD:     w_state_nxt = S_START;
            S_START:    w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!bus.cpu_waiting) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.cpu_waiting) begin
                    if (w_last_word) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt    = r_pc + 1'b1;
                        w_state_nxt = S_LOAD;
`ifdef SEQ_BREAK_EN
                        if (bus.bp_en && (w_pc_nxt == bus.bp_addr)) begin
                            w_state_nxt = S_PAUSE;
                        end
`endif
                    end
                end
            end
            S_HALT:     w_state_nxt = S_IDLE;
`ifdef SEQ_BREAK_EN
            S_PAUSE: begin
                // PC already points at the next word; resume fetches it
                if (bus.run) begin
                    w_state_nxt = S_LOAD;
                end
            end
`endif
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_BREAK_EN
            r_bp_hit <= 1'b0;
`endif
        end else begin
            r_pc <= w_pc_nxt;
            if (w_state_nxt == S_LOAD) begin
                r_instr <= w_rd_data;
            end
            if (w_run_accept) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else if (w_state_nxt == S_HALT) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
`ifdef SEQ_BREAK_EN
            r_bp_hit <= (w_state_nxt == S_PAUSE);
`endif
        end
    end

    // Output decode: strobes come straight from the state so load and
    // start are mutually exclusive by construction.
    always_comb begin
        bus.cpu_load  = (r_state == S_LOAD);
        bus.cpu_start = (r_state == S_START);
    end

    assign bus.cpu_instr = r_instr;
    assign bus.pc        = r_pc;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
`ifdef SEQ_BREAK_EN
    assign bus.bp_hit    = r_bp_hit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. A CPU model answers
//               each start strobe; a monitor records every issued word; a
//               reference model derives the expected issue list from a
//               shadow copy of the program. Honours SEQ_BREAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;
    import cpu_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_sequencer_if #(.AW(AW)) bus();

    instr_sequencer #(.DEPTH(DEPTH), .HALT_OP(OP_HALT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cpu_busy = 3;
    int cpu_ack  = 0;
    int overlap  = 0;

    logic [15:0]   shadow [DEPTH];
    logic [15:0]   q_instr[$];
    logic [15:0]   q_start[$];
    logic [AW-1:0] q_pc[$];

    // CPU model: after a start strobe it optionally lingers, then drops
    // cpu_waiting for cpu_busy cycles.
    initial begin
        bus.cpu_waiting = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.cpu_start === 1'b1) begin
                repeat (cpu_ack) @(posedge clk);
                @(posedge clk);
                #1 bus.cpu_waiting = 1'b0;
                repeat (cpu_busy) @(posedge clk);
                #1 bus.cpu_waiting = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cpu_load === 1'b1) begin
                q_instr.push_back(bus.cpu_instr);
                q_pc.push_back(bus.pc);
            end
            if (bus.cpu_start === 1'b1) q_start.push_back(bus.cpu_instr);
            if (bus.cpu_load === 1'b1 && bus.cpu_start === 1'b1) overlap++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
        @(negedge clk);
        bus.prog_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic clear_mon();
        q_instr.delete(); q_start.delete(); q_pc.delete(); overlap = 0;
    endtask

    task automatic pulse_run();
        @(negedge clk); bus.run = 1'b1;
        @(negedge clk); bus.run = 1'b0;
    endtask

    task automatic check_accepted(input string tag);
        n_assert++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_accept: busy=%b done=%b, required busy=1 done=0", tag, bus.busy, bus.done);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        n_assert++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", tag, bus.done, budget);
        end
    endtask

    // Reference model: words are issued from address 0 upward until one
    // carries the HALT opcode or the last address has been issued.
    task automatic check_program(input string tag);
        logic [15:0] exp_q[$];
        logic [2:0]  op;
        int          n;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(shadow[i]);
            op = shadow[i][15:13];
            if (op == OP_HALT) break;
        end
        n_assert++;
        if (q_instr.size() != exp_q.size() || q_start.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: loads=%0d starts=%0d, required %0d", tag, q_instr.size(), q_start.size(), exp_q.size());
        end
        n = (q_instr.size() < exp_q.size()) ? q_instr.size() : exp_q.size();
        if (q_start.size() < n) n = q_start.size();
        for (int i = 0; i < n; i++) begin
            n_assert++;
            if (q_instr[i] !== exp_q[i] || q_start[i] !== exp_q[i] || q_pc[i] !== AW'(i)) begin
                n_fail++;
                $display("FAIL %s_word%0d: instr=%h start_instr=%h pc=%0d, required instr=%h pc=%0d",
                         tag, i, q_instr[i], q_start[i], q_pc[i], exp_q[i], i);
            end
        end
        n_assert++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.pc !== AW'(exp_q.size() - 1) || overlap != 0) begin
            n_fail++;
            $display("FAIL %s_final: busy=%b done=%b pc=%0d overlap=%0d, required busy=0 done=1 pc=%0d overlap=0",
                     tag, bus.busy, bus.done, bus.pc, overlap, exp_q.size() - 1);
        end
    endtask

    task automatic load_demo();
        write_word(0, 16'hD001);
        write_word(1, 16'hD102);
        write_word(2, 16'hE000);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if ({bus.busy, bus.done, bus.cpu_load, bus.cpu_start} !== 4'b0 || bus.pc !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b load=%b start=%b pc=%0d, required all 0",
                     bus.busy, bus.done, bus.cpu_load, bus.cpu_start, bus.pc);
        end
    endtask

    task automatic test_single_run();
        cpu_busy = 3; cpu_ack = 0;
        load_demo();
        clear_mon();
        pulse_run();
        check_accepted("single");
        wait_done("single", 100);
        check_program("single");
    endtask

    task automatic test_end_of_memory();
        for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 16'hD0FF);
        clear_mon();
        pulse_run();
        check_accepted("eom");
        wait_done("eom", 400);
        check_program("eom");
        repeat (6) @(negedge clk);
        n_assert++;
        if (q_instr.size() != DEPTH) begin
            n_fail++;
            $display("FAIL eom_nowrap: loads=%0d, required %0d", q_instr.size(), DEPTH);
        end
    endtask

    task automatic test_ignored_inputs();
        logic [AW-1:0] pc_before;
        int            n = 0;
        cpu_busy = 3; cpu_ack = 0;
        load_demo();
        clear_mon();
        pulse_run();
        while (bus.cpu_waiting !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        pc_before = bus.pc;
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        n_assert++;
        if (bus.pc !== pc_before || q_instr.size() != 1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_while_busy: pc=%0d loads=%0d busy=%b, required pc=%0d loads=1 busy=1",
                     bus.pc, q_instr.size(), bus.busy, pc_before);
        end
        bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_data = 16'h1234;
        @(negedge clk);
        bus.prog_we = 1'b0;
        wait_done("ignored", 100);
        check_program("ignored");
        clear_mon();
        pulse_run();
        wait_done("readback", 100);
        check_program("readback");
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        cpu_busy = 3; cpu_ack = 3;
        clear_mon();
        pulse_run();
        while (bus.cpu_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({bus.cpu_load, bus.cpu_start, bus.cpu_instr, bus.pc, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: load=%b start=%b instr=%h pc=%0d busy=%b done=%b, required all 0",
                     bus.cpu_load, bus.cpu_start, bus.cpu_instr, bus.pc, bus.busy, bus.done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        cpu_ack = 0;
        clear_mon();
        pulse_run();
        check_accepted("restart");
        wait_done("restart", 100);
        check_program("restart");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [15:0] d;
        for (int it = 0; it < 6; it++) begin
            cpu_busy = int'($urandom_range(1, 4));
            cpu_ack  = int'($urandom_range(0, 2));
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 5) == 0) op = OP_HALT;
                else op = 3'($urandom_range(0, 6));
                d = {op, 13'($urandom)};
                write_word(AW'(i), d);
            end
            clear_mon();
            pulse_run();
            check_accepted("random");
            wait_done("random", 400);
            check_program("random");
        end
        cpu_ack = 0;
    endtask

`ifdef SEQ_BREAK_EN
    task automatic test_break();
        int n = 0;
        cpu_busy = 3; cpu_ack = 0;
        load_demo();
        bus.bp_en = 1'b1; bus.bp_addr = 1;
        clear_mon();
        pulse_run();
        while (bus.bp_hit !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        n_assert++;
        if (bus.bp_hit !== 1'b1 || bus.pc !== AW'(1) || bus.busy !== 1'b1 || q_instr.size() != 1) begin
            n_fail++;
            $display("FAIL bp_pause: bp_hit=%b pc=%0d busy=%b loads=%0d, required 1/1/1/1",
                     bus.bp_hit, bus.pc, bus.busy, q_instr.size());
        end
        pulse_run();
        n_assert++;
        if (bus.bp_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_resume: bp_hit=%b, required 0", bus.bp_hit);
        end
        wait_done("bp", 100);
        check_program("bp");
        bus.bp_en = 1'b0;
    endtask
`endif

    initial begin
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.run = 1'b0;
`ifdef SEQ_BREAK_EN
        bus.bp_en = 1'b0; bus.bp_addr = '0;
`endif
        test_reset();
        test_single_run();
        test_end_of_memory();
        test_ignored_inputs();
        test_reset_midrun();
        test_random();
`ifdef SEQ_BREAK_EN
        test_break();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
